// File: rtl/imem_loader_rv32i.sv
// Boot loader: receives a framed byte stream (SYNC, LEN_LO, LEN_HI, payload, CHK),
// packs the payload into little-endian words for the instruction memory and releases the core only after a verified load.
module imem_loader_rv32i #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, WRITE, CHECK, DONE, ERROR
    } state_t;

    localparam logic [16:0]       DEPTH_L   = 17'(IMEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

    state_t            state, state_nxt;
    logic [15:0]       n_words, n_words_nxt;
    logic [1:0]        idx, idx_nxt;
    logic [31:0]       asm_word, asm_nxt;
    logic [7:0]        chk, chk_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [15:0]       words_nxt;
    logic              core_nxt, busy_nxt, done_nxt, err_nxt;
    logic              accept;
    logic [15:0]       n_len;

    assign in_ready   = (state != WRITE);
    assign imem_we    = (state == WRITE);
    assign imem_wdata = asm_word;
    assign accept     = in_valid && in_ready;
    assign n_len      = {in_data, n_words[7:0]};

    always_comb begin
        state_nxt   = state;
        n_words_nxt = n_words;
        idx_nxt     = idx;
        asm_nxt     = asm_word;
        chk_nxt     = chk;
        waddr_nxt   = imem_waddr;
        words_nxt   = words_loaded;
        core_nxt    = core_rst_n;
        busy_nxt    = busy;
        done_nxt    = done;
        err_nxt     = err;

        case (state)
            IDLE, DONE, ERROR: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_nxt = LEN0;
                    chk_nxt   = '0;
                    words_nxt = '0;
                    waddr_nxt = '0;
                    idx_nxt   = '0;
                    core_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            LEN0: begin
                if (accept) begin
                    n_words_nxt[7:0] = in_data;
                    state_nxt        = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    n_words_nxt = n_len;
                    if ({1'b0, n_len} > DEPTH_L) begin
                        state_nxt = ERROR;
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        core_nxt  = 1'b0;
                    end else if (n_len == '0) begin
                        state_nxt = CHECK;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    case (idx)
                        2'd0:    asm_nxt[7:0]   = in_data;
                        2'd1:    asm_nxt[15:8]  = in_data;
                        2'd2:    asm_nxt[23:16] = in_data;
                        default: asm_nxt[31:24] = in_data;
                    endcase
                    chk_nxt = chk ^ in_data;
                    idx_nxt = idx + 2'd1;
                    if (idx == 2'd3) state_nxt = WRITE;
                end
            end
            WRITE: begin
                // Wrap only after the write to the last valid word, so a full-depth image never writes past it.
                waddr_nxt = (imem_waddr == LAST_ADDR) ? '0 : imem_waddr + 1'b1;
                words_nxt = words_loaded + 16'd1;
                state_nxt = (words_loaded + 16'd1 == n_words) ? CHECK : DATA;
            end
            CHECK: begin
                if (accept) begin
                    busy_nxt = 1'b0;
                    if (in_data == chk) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        core_nxt  = 1'b1;
                    end else begin
                        state_nxt = ERROR;
                        err_nxt   = 1'b1;
                        core_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            n_words      <= '0;
            idx          <= '0;
            asm_word     <= '0;
            chk          <= '0;
            imem_waddr   <= '0;
            words_loaded <= '0;
            core_rst_n   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            n_words      <= n_words_nxt;
            idx          <= idx_nxt;
            asm_word     <= asm_nxt;
            chk          <= chk_nxt;
            imem_waddr   <= waddr_nxt;
            words_loaded <= words_nxt;
            core_rst_n   <= core_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
        end
    end

endmodule

// File: tb/tb_imem_loader_rv32i.sv
// Directed bench for imem_loader_rv32i: framed loads, checksum errors, length limits,
// sparse valid, full-depth image and mid-frame reset.
module tb_imem_loader_rv32i;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst_n, busy, done, err;
    logic [15:0] words_loaded;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned rdy_bad = 0;
    bit          toggle  = 1'b0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] payload[$];

    imem_loader_rv32i #(.IMEM_DEPTH(256), .ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && imem_we) begin
            wr_addr.push_back(imem_waddr);
            wr_data.push_back(imem_wdata);
            if (in_ready !== 1'b0) rdy_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int unsigned tries = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && tries < 8) begin
            @(negedge clk);
            tries++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL handshake_timeout: in_ready=%b, required 1", in_ready);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (toggle) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] n, input logic [7:0] chk);
        logic [31:0] w;
        wr_addr.delete(); wr_data.delete(); rdy_bad = 0;
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        foreach (payload[i]) begin
            w = payload[i];
            send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]); send_byte(w[31:24]);
        end
        send_byte(chk);
    endtask

    task automatic check_flags(input string name, input logic e_core, input logic e_busy,
                               input logic e_done, input logic e_err);
        n_tests++;
        if ({core_rst_n, busy, done, err} !== {e_core, e_busy, e_done, e_err}) begin
            n_fail++;
            $display("FAIL %s flags: core/busy/done/err=%b%b%b%b, required %b%b%b%b", name,
                     core_rst_n, busy, done, err, e_core, e_busy, e_done, e_err);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({in_ready, imem_we, imem_waddr, imem_wdata, words_loaded} !== {1'b1, 1'b0, 8'h00, 32'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%h data=%h words=%0d, required 1 0 00 00000000 0",
                     in_ready, imem_we, imem_waddr, imem_wdata, words_loaded);
        end
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_two_word(input logic [7:0] chk, input logic good);
        payload.delete();
        payload.push_back(32'h0000_0013);
        payload.push_back(32'h0010_0093);
        send_frame(16'd2, chk);
        n_tests++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 8'd0 || wr_addr[1] !== 8'd1 ||
            wr_data[0] !== 32'h0000_0013 || wr_data[1] !== 32'h0010_0093) begin
            n_fail++;
            $display("FAIL two_word_writes: count=%0d, required 2 writes 0:00000013 1:00100093", wr_addr.size());
        end
        n_tests++;
        if (rdy_bad != 0) begin
            n_fail++;
            $display("FAIL write_ready: in_ready high in %0d write cycles, required 0", rdy_bad);
        end
        n_tests++;
        if (words_loaded !== 16'd2) begin
            n_fail++;
            $display("FAIL two_word_count: words_loaded=%0d, required 2", words_loaded);
        end
        if (good) check_flags("two_word_ok", 1'b1, 1'b0, 1'b1, 1'b0);
        else      check_flags("two_word_badchk", 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_zero_and_oversize();
        payload.delete();
        send_frame(16'd0, 8'h00);
        n_tests++;
        if (wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL zero_len_writes: count=%0d, required 0", wr_addr.size());
        end
        check_flags("zero_len", 1'b1, 1'b0, 1'b1, 1'b0);
        wr_addr.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        repeat (3) @(negedge clk);
        n_tests++;
        if (wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL oversize_writes: count=%0d, required 0", wr_addr.size());
        end
        check_flags("oversize", 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_garbage_and_sparse();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL garbage_ready: in_ready=%b, required 1", in_ready);
        end
        check_flags("garbage", 1'b0, 1'b0, 1'b0, 1'b1);
        toggle = 1'b1;
        payload.delete();
        payload.push_back(32'h1234_5678);
        send_frame(16'd1, 8'h08);
        toggle = 1'b0;
        n_tests++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL sparse_write: count=%0d, required 1 write 0:12345678", wr_addr.size());
        end
        check_flags("sparse", 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_full_depth();
        int unsigned bad = 0;
        logic [31:0] w;
        payload.delete();
        for (int i = 0; i < 256; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            payload.push_back(w);
        end
        send_frame(16'd256, 8'h00);
        n_tests++;
        if (wr_addr.size() != 256) begin
            n_fail++;
            $display("FAIL full_count: writes=%0d, required 256", wr_addr.size());
        end else begin
            for (int i = 0; i < 256; i++)
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== payload[i]) bad++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL full_contents: %0d bad writes, required 0", bad);
            end
            n_tests++;
            if (wr_data[255] !== 32'hFFFE_FDFC) begin
                n_fail++;
                $display("FAIL full_last: data=%h, required fffefdfc", wr_data[255]);
            end
        end
        n_tests++;
        if (imem_waddr !== 8'd0 || words_loaded !== 16'd256) begin
            n_fail++;
            $display("FAIL full_final: addr=%h words=%0d, required 00 256", imem_waddr, words_loaded);
        end
        check_flags("full_done", 1'b1, 1'b0, 1'b1, 1'b0);
        send_byte(8'hA5);
        check_flags("restart_sync", 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE);
        check_flags("mid_busy", 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_flags("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        payload.delete();
        payload.push_back(32'hDEAD_BEEF);
        send_frame(16'd1, 8'h22);
        n_tests++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL post_reset_write: count=%0d, required 1 write 0:deadbeef", wr_addr.size());
        end
        check_flags("post_reset", 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_two_word(8'h90, 1'b1);
        test_two_word(8'h91, 1'b0);
        test_zero_and_oversize();
        test_garbage_and_sparse();
        test_full_depth();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
